// File: rtl/ccff_chain_loader.sv
// Serial loader for one frac_logic configuration chain: takes words on a valid/ready
// stream and shifts CHAIN_LEN bits onto ccff_head, LSB first. Optional CCFF_READBACK_EN adds tail capture.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 21,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 5
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [WORD_W-1:0] word_buf;
  logic              head_hold;
  logic              capture;

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      head_hold <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      head_hold <= ccff_head;
    end
  end

  // The word buffer is pure data and only written on an accepted transfer
  always_ff @(posedge prog_clk) begin
    if (capture)
      word_buf <= cfg_data;
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    capture       = 1'b0;
    cfg_ready     = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = head_hold;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        busy      = 1'b1;
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          capture   = 1'b1;
          idx_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = word_buf[idx];
        cnt_nxt       = cnt + 1'b1;
        idx_nxt       = idx + 1'b1;
        // The chain-length test wins so surplus bits of the last word are dropped
        if (cnt == CNT_LAST)
          state_nxt = DONE;
        else if (idx == IDX_LAST)
          state_nxt = LOAD;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_acc;
  logic [WORD_W-1:0] rb_word;

  always_comb rb_word = rb_acc | (WORD_W'(ccff_tail) << idx);

  // Tail bits are packed at the same index as the bit being shifted in
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      rb_valid <= 1'b0;
      rb_acc   <= '0;
    end else begin
      rb_valid <= 1'b0;
      if (abort || start) begin
        rb_acc <= '0;
      end else if (ccff_shift_en) begin
        if (idx == IDX_LAST || cnt == CNT_LAST) begin
          rb_valid <= 1'b1;
          rb_acc   <= '0;
        end else begin
          rb_acc <= rb_word;
        end
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (ccff_shift_en && (idx == IDX_LAST || cnt == CNT_LAST))
      rb_data <= rb_word;
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule
